wave_column_fetch: RTL and testbench
====================================

# wave_column_fetch

Display-side reader for the dual-channel capture RAM. When the capture stage raises `display_en`, this block:
- reads the 16384-entry circular buffer, centred on the latched trigger address;
- compresses each group of consecutive samples into one screen column of per-channel min/max;
- streams the columns to the renderer over a valid/ready handshake;
- answers with a four-phase `display_done`.

It runs entirely in the RAM read-port clock domain.

## Interface
Parameters:
- COLS, 800, screen columns per frame (even, ≤ 1023)
- ADDR_W, 14, capture-buffer address width (depth = 2^ADDR_W)
- RD_LAT, 2, RAM read latency in cycles, from address/enable to valid `dout`
- MAX_ZOOM, 4, largest legal zoom_shift; requires COLS<<MAX_ZOOM ≤ 2^ADDR_W

Ports:
- clk  in  1  clock (RAM read-port clock)
- rst  in  1  synchronous, active-high reset
- display_en  in  1  frame request from capture domain (asynchronous; synchronised here)
- display_done  out  1  frame complete, four-phase acknowledge
- trig_pos  in  14  buffer address of the trigger sample; stable while display_en is high
- h_offset  in  14  signed horizontal shift in samples
- zoom_shift  in  3  samples per column = 1<<zoom_shift
- read_enable  out  1  RAM read-port enable
- ram_data_addr  out  15  RAM read address; bit 14 is always 0
- ram_data_out_a  in  8  channel A RAM data
- ram_data_out_b  in  8  channel B RAM data
- col_valid  out  1  column result valid
- col_ready  in  1  renderer accepts the column
- col_idx  out  10  column index, 0..COLS-1
- col_min_a, col_max_a, col_min_b, col_max_b  out  8 each  per-column extrema
- busy  out  1  high in every state except IDLE

## Operation
- display_en passes through a 2-flop synchroniser. en_s is the synchronised value.
- States: IDLE, SETUP, FETCH, DRAIN, EMIT, DONE.
- IDLE: on en_s=1 → SETUP.
- SETUP (1 cycle):
  - latch z = min(zoom_shift, MAX_ZOOM);
  - latch base = (trig_pos + h_offset − ((COLS/2)<<z)) mod 2^ADDR_W;
  - all address arithmetic is ADDR_W bits and wraps silently;
  - clear col counter → FETCH.
- FETCH:
  - read_enable=1 every cycle; ram_data_addr = base + (col<<z) + k, mod 2^ADDR_W, k = 0..(1<<z)−1;
  - after k=(1<<z)−1 → DRAIN.
- Data return:
  - an RD_LAT-deep valid shift register tags returning data;
  - the first tagged sample of a column loads min/max;
  - each later tagged sample updates min = smaller, max = larger, unsigned compare.
- DRAIN: read_enable=0; when the last tagged sample has been absorbed → EMIT.
- EMIT: col_valid=1; outputs hold stable until col_ready=1. On accept:
  - if col=COLS−1 → DONE;
  - otherwise col+1 → FETCH.
- DONE: display_done=1, held until en_s=0, then display_done=0 → IDLE.
- Abort: en_s=0 in FETCH/DRAIN/EMIT:
  - finish the current column's outstanding reads;
  - drop the column (no col_valid);
  - → IDLE without asserting display_done.
- z=0: one sample per column; min=max=sample.
- A zoom_shift above MAX_ZOOM is clamped, never wrapped.

## Timing
- Reset values:
  - display_done, read_enable, col_valid, busy = 0;
  - ram_data_addr, col_idx = 0;
  - all min/max outputs = 0;
  - state = IDLE;
  - synchroniser flops = 0.
- Request to first read: display_en rise → 2 sync cycles + 1 IDLE + 1 SETUP → read_enable high on the 5th clk.
- Per column: (1<<z) FETCH cycles + RD_LAT DRAIN cycles + ≥1 EMIT cycle.
  - With col_ready tied high, a column takes (1<<z)+RD_LAT+1 cycles.
- col_valid rises the cycle after the last sample is absorbed.
  - Data and col_idx are registered and do not change while col_valid=1 && col_ready=0.
- display_done rises 1 cycle after the last column is accepted.
  - It falls 1 cycle after en_s is seen low (3 clk after display_en falls).
- rst high mid-frame: all outputs take their reset values on the next clk; no partial column is emitted.

## Test plan
- Ramp RAM (mem[i]=i[7:0] on A, ~i[7:0] on B), trig_pos=8192, h_offset=0, z=0, COLS=800, ready=1:
  - first address 7792, last address 8591;
  - column 0 min=max=A:0x70, B:0x8F;
  - 800 col_valid pulses, then display_done.
- z=2, same RAM: column 0 reads 6592..6595; min_a=0xC0, max_a=0xC3, min_b=0x3C, max_b=0x3F.
- Wrap: trig_pos=100, z=0 → first address 16084; address sequence wraps 16383→0 with no gap.
- zoom_shift=7 → behaves as z=4; 16 reads per column; last read address = base+12799.
- Backpressure: col_ready low for 5 cycles during column 3 → col_valid and data stable for 5 cycles; no reads issued meanwhile.
- Handshake corner cases:
  - display_en dropped during column 10 → no display_done, busy→0, no further col_valid;
  - rst asserted mid-FETCH → all outputs 0 the next cycle.

Source files
------------

// File: rtl/wave_column_fetch.sv
// rtl/wave_column_fetch.sv - capture-RAM reader producing per-column min/max for display.
// Reads a window centred on the trigger address and streams one extrema set per column.
module wave_column_fetch #(
  parameter int COLS     = 800,
  parameter int ADDR_W   = 14,
  parameter int RD_LAT   = 2,
  parameter int MAX_ZOOM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              display_en,
  output logic              display_done,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [ADDR_W-1:0] h_offset,
  input  logic [2:0]        zoom_shift,
  output logic              read_enable,
  output logic [ADDR_W:0]   ram_data_addr,
  input  logic [7:0]        ram_data_out_a,
  input  logic [7:0]        ram_data_out_b,
  output logic              col_valid,
  input  logic              col_ready,
  output logic [9:0]        col_idx,
  output logic [7:0]        col_min_a,
  output logic [7:0]        col_max_a,
  output logic [7:0]        col_min_b,
  output logic [7:0]        col_max_b,
  output logic              busy
);

  localparam int DW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_DRAIN, S_EMIT, S_DONE
  } state_t;

  state_t state, state_next;

  logic              en_s1, en_s;
  logic [2:0]        zoom;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] k;
  logic [RD_LAT-1:0] vld;
  logic [DW-1:0]     drain_cnt;
  logic              first;
  logic              abort;

  logic [2:0]        zoom_c;
  logic [ADDR_W-1:0] base_c;
  logic [ADDR_W-1:0] span_m1;
  logic              last_k;
  logic              last_col;

  // Out-of-range zoom saturates so the window never exceeds the buffer.
  assign zoom_c   = (zoom_shift > 3'(MAX_ZOOM)) ? 3'(MAX_ZOOM) : zoom_shift;
  assign base_c   = trig_pos + h_offset - (ADDR_W'(COLS / 2) << zoom_c);
  assign span_m1  = (ADDR_W'(1) << zoom) - ADDR_W'(1);
  assign last_k   = (k == span_m1);
  assign last_col = (col_idx == 10'(COLS - 1));

  assign read_enable   = (state == S_FETCH);
  assign col_valid     = (state == S_EMIT);
  assign display_done  = (state == S_DONE);
  assign busy          = (state != S_IDLE);
  assign ram_data_addr = {1'b0, addr};

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (en_s) state_next = S_SETUP;
      S_SETUP: state_next = en_s ? S_FETCH : S_IDLE;
      S_FETCH: if (!en_s || last_k) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt == DW'(RD_LAT - 1))
                 state_next = (abort || !en_s) ? S_IDLE : S_EMIT;
      S_EMIT: begin
        if (!en_s)          state_next = S_IDLE;
        else if (col_ready) state_next = last_col ? S_DONE : S_FETCH;
      end
      S_DONE:  if (!en_s) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      en_s1     <= 1'b0;
      en_s      <= 1'b0;
      zoom      <= 3'd0;
      addr      <= '0;
      k         <= '0;
      vld       <= '0;
      drain_cnt <= '0;
      first     <= 1'b0;
      abort     <= 1'b0;
      col_idx   <= 10'd0;
      col_min_a <= 8'd0;
      col_max_a <= 8'd0;
      col_min_b <= 8'd0;
      col_max_b <= 8'd0;
    end else begin
      en_s1 <= display_en;
      en_s  <= en_s1;
      state <= state_next;
      vld   <= (vld << 1) | RD_LAT'(read_enable);

      case (state)
        S_SETUP: begin
          zoom    <= zoom_c;
          addr    <= base_c;
          col_idx <= 10'd0;
          k       <= '0;
          first   <= 1'b1;
          abort   <= 1'b0;
        end
        // Columns are contiguous, so the address just keeps incrementing.
        S_FETCH: begin
          addr      <= addr + ADDR_W'(1);
          k         <= k + ADDR_W'(1);
          drain_cnt <= '0;
          if (!en_s) abort <= 1'b1;
        end
        S_DRAIN: drain_cnt <= drain_cnt + DW'(1);
        S_EMIT: begin
          if (en_s && col_ready && !last_col) begin
            col_idx <= col_idx + 10'd1;
            k       <= '0;
            first   <= 1'b1;
          end
        end
        default: ;
      endcase

      if (vld[RD_LAT-1]) begin
        first <= 1'b0;
        if (first) begin
          col_min_a <= ram_data_out_a;
          col_max_a <= ram_data_out_a;
          col_min_b <= ram_data_out_b;
          col_max_b <= ram_data_out_b;
        end else begin
          if (ram_data_out_a < col_min_a) col_min_a <= ram_data_out_a;
          if (ram_data_out_a > col_max_a) col_max_a <= ram_data_out_a;
          if (ram_data_out_b < col_min_b) col_min_b <= ram_data_out_b;
          if (ram_data_out_b > col_max_b) col_max_b <= ram_data_out_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_column_fetch.sv
// tb/tb_wave_column_fetch.sv - scoreboard bench for wave_column_fetch.
// Ramp RAM model; expected reads and columns are queued at stimulus time.
module tb_wave_column_fetch;

  localparam int COLS = 800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        display_en = 1'b0;
  logic        display_done;
  logic [13:0] trig_pos = 14'd0;
  logic [13:0] h_offset = 14'd0;
  logic [2:0]  zoom_shift = 3'd0;
  logic        read_enable;
  logic [14:0] ram_data_addr;
  logic [7:0]  ram_data_out_a, ram_data_out_b;
  logic        col_valid;
  logic        col_ready = 1'b1;
  logic [9:0]  col_idx;
  logic [7:0]  col_min_a, col_max_a, col_min_b, col_max_b;
  logic        busy;

  always #5 clk = ~clk;

  wave_column_fetch #(.COLS(COLS), .ADDR_W(14), .RD_LAT(2), .MAX_ZOOM(4)) dut (
    .clk(clk), .rst(rst), .display_en(display_en), .display_done(display_done),
    .trig_pos(trig_pos), .h_offset(h_offset), .zoom_shift(zoom_shift),
    .read_enable(read_enable), .ram_data_addr(ram_data_addr),
    .ram_data_out_a(ram_data_out_a), .ram_data_out_b(ram_data_out_b),
    .col_valid(col_valid), .col_ready(col_ready), .col_idx(col_idx),
    .col_min_a(col_min_a), .col_max_a(col_max_a),
    .col_min_b(col_min_b), .col_max_b(col_max_b), .busy(busy)
  );

  // Two-stage read pipeline: mem[i] = i[7:0] on A, ~i[7:0] on B.
  logic [7:0] p0a = 8'd0, p0b = 8'd0, p1a = 8'd0, p1b = 8'd0;
  always @(posedge clk) begin
    if (read_enable) begin
      p0a <= ram_data_addr[7:0];
      p0b <= ~ram_data_addr[7:0];
    end
    p1a <= p0a;
    p1b <= p0b;
  end
  assign ram_data_out_a = p1a;
  assign ram_data_out_b = p1b;

  wire [41:0] col_vec = {col_idx, col_min_a, col_max_a, col_min_b, col_max_b};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [14:0] exp_addr_q[$];
  logic [41:0] exp_col_q[$];

  function automatic logic [41:0] exp_col(input logic [13:0] base, input int z, input int c);
    logic [13:0] a;
    logic [7:0]  mna, mxa, mnb, mxb, da, db;
    mna = 8'hFF; mxa = 8'h00; mnb = 8'hFF; mxb = 8'h00;
    for (int i = 0; i < (1 << z); i++) begin
      a  = base + 14'((c << z) + i);
      da = a[7:0];
      db = ~a[7:0];
      if (da < mna) mna = da;
      if (da > mxa) mxa = da;
      if (db < mnb) mnb = db;
      if (db > mxb) mxb = db;
    end
    return {10'(c), mna, mxa, mnb, mxb};
  endfunction

  // Monitor state shared with the directed checks.
  int          n_cols = 0;
  int          n_reads = 0;
  logic [14:0] first_addr = '0, last_addr = '0;
  logic [41:0] col0 = '0;
  bit          wrap_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (read_enable) begin
        if (n_reads == 0) first_addr = ram_data_addr;
        if (n_reads > 0 && last_addr == 15'd16383 && ram_data_addr == 15'd0) wrap_seen = 1;
        last_addr = ram_data_addr;
        n_reads++;
        if (exp_addr_q.size() == 0) check("unexpected_read", {49'd0, ram_data_addr}, 64'h7FFF_FFFF);
        else check("rd_addr", {49'd0, ram_data_addr}, {49'd0, exp_addr_q.pop_front()});
      end
      if (col_valid && col_ready) begin
        if (n_cols == 0) col0 = col_vec;
        n_cols++;
        if (exp_col_q.size() == 0) check("unexpected_col", {22'd0, col_vec}, 64'hFFFF_FFFF_FFFF);
        else check("column", {22'd0, col_vec}, {22'd0, exp_col_q.pop_front()});
      end
    end
  end

  // Stalls the renderer for 5 cycles while column 3 is offered.
  bit bp_arm = 0;
  initial begin
    logic [41:0] held;
    forever begin
      @(negedge clk);
      #1;
      if (bp_arm && col_valid && col_idx == 10'd3) begin
        bp_arm    = 0;
        held      = col_vec;
        col_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          #1;
          check("bp_hold", {21'd0, col_valid, col_vec, read_enable}, {21'd0, 1'b1, held, 1'b0});
        end
        col_ready = 1'b1;
      end
    end
  end

  task automatic load_frame(input logic [13:0] tp, input logic [13:0] ho, input logic [2:0] zs,
                            output logic [13:0] base, output int zc);
    trig_pos   = tp;
    h_offset   = ho;
    zoom_shift = zs;
    zc   = (zs > 3'd4) ? 4 : int'(zs);
    base = tp + ho - 14'(400 << zc);
    exp_addr_q.delete();
    exp_col_q.delete();
    for (int i = 0; i < (COLS << zc); i++) exp_addr_q.push_back({1'b0, base + 14'(i)});
    for (int c = 0; c < COLS; c++) exp_col_q.push_back(exp_col(base, zc, c));
    n_cols = 0;
    n_reads = 0;
    wrap_seen = 0;
  endtask

  task automatic run_frame(input logic [13:0] tp, input logic [13:0] ho, input logic [2:0] zs,
                           input bit check_lat);
    logic [13:0] base;
    int zc, lat, cyc;
    load_frame(tp, ho, zs, base, zc);
    @(negedge clk);
    display_en = 1'b1;
    lat = 0;
    while (!read_enable && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (check_lat) check("req_to_read", 64'(lat), 64'd4);
    cyc = 0;
    while (!display_done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", {63'd0, display_done}, 64'd1);
    check("col_count", 64'(n_cols), 64'(COLS));
    check("read_count", 64'(n_reads), 64'(COLS << zc));
    check("queues_empty", 64'(exp_addr_q.size() + exp_col_q.size()), 64'd0);
    display_en = 1'b0;
    repeat (2) @(negedge clk);
    check("done_hold", {62'd0, display_done, busy}, 64'd3);
    @(negedge clk);
    check("done_fall", {62'd0, display_done, busy}, 64'd0);
  endtask

  initial begin
    logic [13:0] base;
    int zc, cyc, cols_at_drop;
    bit done_flag;

    repeat (3) @(negedge clk);
    check("reset_state", {22'd0, display_done, read_enable, col_valid, busy, ram_data_addr, col_vec},
          64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp, centred at 8192, one sample per column, with a stall on column 3.
    bp_arm = 1;
    run_frame(14'd8192, 14'd0, 3'd0, 1);
    check("z0_first_addr", {49'd0, first_addr}, 64'd7792);
    check("z0_last_addr", {49'd0, last_addr}, 64'd8591);
    check("z0_col0", {22'd0, col0}, {22'd0, 10'd0, 8'h70, 8'h70, 8'h8F, 8'h8F});
    check("bp_consumed", {63'd0, bp_arm}, 64'd0);

    run_frame(14'd8192, 14'd0, 3'd2, 0);
    check("z2_first_addr", {49'd0, first_addr}, 64'd6592);
    check("z2_col0", {22'd0, col0}, {22'd0, 10'd0, 8'hC0, 8'hC3, 8'h3C, 8'h3F});

    run_frame(14'd100, 14'd0, 3'd0, 0);
    check("wrap_first_addr", {49'd0, first_addr}, 64'd16084);
    check("wrap_seen", {63'd0, wrap_seen}, 64'd1);

    // zoom_shift=7 clamps to 4: base 1792, 12800 reads.
    run_frame(14'd8192, 14'd0, 3'd7, 0);
    check("clamp_reads", 64'(n_reads), 64'd12800);
    check("clamp_last_addr", {49'd0, last_addr}, 64'd14591);

    // Abort during column 10.
    load_frame(14'd8192, 14'd0, 3'd0, base, zc);
    @(negedge clk);
    display_en = 1'b1;
    cyc = 0;
    while (!(read_enable && col_idx == 10'd10) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reach_col10", {54'd0, col_idx}, 64'd10);
    display_en = 1'b0;
    cols_at_drop = n_cols;
    done_flag = 0;
    cyc = 0;
    while (cyc < 30) begin
      @(negedge clk);
      if (display_done) done_flag = 1;
      cyc++;
    end
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_no_done", {63'd0, done_flag}, 64'd0);
    check("abort_cols", 64'(n_cols), 64'd10);
    check("abort_cols_at_drop", 64'(cols_at_drop), 64'd10);
    exp_addr_q.delete();
    exp_col_q.delete();

    // Reset in the middle of FETCH.
    load_frame(14'd8192, 14'd0, 3'd2, base, zc);
    @(negedge clk);
    display_en = 1'b1;
    cyc = 0;
    while (!(read_enable && col_idx == 10'd2) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_fetch", {62'd0, read_enable, busy}, 64'd3);
    rst = 1'b1;
    display_en = 1'b0;
    @(negedge clk);
    check("rst_midframe", {22'd0, display_done, read_enable, col_valid, busy, ram_data_addr, col_vec},
          64'd0);
    rst = 1'b0;
    exp_addr_q.delete();
    exp_col_q.delete();
    repeat (5) @(negedge clk);
    check("rst_quiet", {61'd0, display_done, col_valid, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
